risc_v_fetch_queue: RTL and testbench

Instruction fetch front end for the five-stage core. It issues word-addressed reads to instruction memory and buffers the returned instructions in a small FIFO. It presents them, each with its next-PC, to the decode stage through a valid/ready handshake. It services taken-branch redirects from execute by flushing the queue and all in-flight reads.

---
 rtl/risc_v_fetch_queue_if.sv | 22 ++
 rtl/risc_v_fetch_queue.sv | 57 +++++
 tb/tb_risc_v_fetch_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/risc_v_fetch_queue_if.sv
// risc_v_fetch_queue_if: fetch front-end bus bundle (imem read port, branch redirect, decode handshake, flush counter)
// master: the fetch queue; slave: memory/execute/decode side
interface risc_v_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        br_en;
  logic [31:0] br_target;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_ir;
  logic [31:0] fq_npc;
  logic [15:0] flush_cnt;
  modport master (
    output imem_req, imem_addr, fq_valid, fq_ir, fq_npc, flush_cnt,
    input  imem_rdata, br_en, br_target, fq_ready
  );
  modport slave (
    input  imem_req, imem_addr, fq_valid, fq_ir, fq_npc, flush_cnt,
    output imem_rdata, br_en, br_target, fq_ready
  );
endinterface

// File: rtl/risc_v_fetch_queue.sv
// risc_v_fetch_queue: instruction fetch front end with DEPTH-entry queue and branch-redirect flush
// ports: clk, RN (sync active-high reset), bus (master): imem_req/imem_addr/imem_rdata,
//        br_en/br_target, fq_valid/fq_ready/fq_ir/fq_npc, flush_cnt
module risc_v_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic                    clk,
  input logic                    RN,
  risc_v_fetch_queue_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   r_pc, r_addr;
  logic          r_inflight;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic [15:0]   r_flush;
  logic          w_req, w_push, w_pop;
  // credit uses registered count/inflight only, so a pop frees a slot one cycle later
  assign w_req  = !RN && !bus.br_en &&
                  (({1'b0, r_count} + {{(AW+1){1'b0}}, r_inflight}) < (AW+2)'(DEPTH));
  assign w_push = r_inflight && !bus.br_en && !RN;
  assign w_pop  = bus.fq_valid && bus.fq_ready;
  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.fq_valid  = !RN && !bus.br_en && (r_count != '0);
  assign {bus.fq_ir, bus.fq_npc} = r_mem[r_head];
  assign bus.flush_cnt = r_flush;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail] <= {bus.imem_rdata, r_addr + 32'd1};
  always_ff @(posedge clk) begin
    if (RN) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_addr     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_flush    <= '0;
    end else if (bus.br_en) begin
      r_pc       <= bus.br_target;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_flush    <= r_flush + 16'(r_flush != 16'hFFFF);
    end else begin
      if (w_req) r_pc <= r_pc + 32'd1;
      r_inflight <= w_req;
      r_addr     <= r_pc;
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_risc_v_fetch_queue.sv
// tb_risc_v_fetch_queue: directed self-checking bench for risc_v_fetch_queue
module tb_risc_v_fetch_queue;
  logic clk = 1'b0;
  logic RN  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   nreq;
  risc_v_fetch_queue_if bus();
  risc_v_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (.clk(clk), .RN(RN), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? mem(bus.imem_addr) : 32'hDEAD_BEEF;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic rn, input logic br, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    RN = rn; bus.br_en = br; bus.br_target = tgt; bus.fq_ready = rdy;
    #1;
  endtask
  task automatic reset_dut(input logic rdy);
    drive(1'b1, 1'b0, 32'd0, rdy);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.fq_valid), 32'd0);
    drive(1'b1, 1'b0, 32'd0, rdy);
  endtask
  initial begin
    bus.br_en = 1'b0; bus.br_target = 32'd0; bus.fq_ready = 1'b0;
    // fill from reset
    reset_dut(1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("c0_req", 32'(bus.imem_req), 32'd1);
    chk("c0_addr", bus.imem_addr, 32'd0);
    chk("c0_valid", 32'(bus.fq_valid), 32'd0);
    chk("c0_flush", 32'(bus.flush_cnt), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("c1_valid", 32'(bus.fq_valid), 32'd0);
    chk("c1_addr", bus.imem_addr, 32'd1);
    for (int k = 2; k < 6; k++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("fill_valid", 32'(bus.fq_valid), 32'd1);
      chk("fill_ir", bus.fq_ir, 32'h1000_0000 + 32'(k - 2));
      chk("fill_npc", bus.fq_npc, 32'(k - 1));
    end
    // backpressure from reset
    reset_dut(1'b0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0);
      if (bus.imem_req) begin
        chk("bp_addr", bus.imem_addr, 32'(nreq));
        nreq++;
      end
    end
    chk("bp_nreq", 32'(nreq), 32'd4);
    chk("bp_count", 32'(dut.r_count), 32'd4);
    chk("bp_req_idle", 32'(bus.imem_req), 32'd0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("drain_valid", 32'(bus.fq_valid), 32'd1);
      chk("drain_ir", bus.fq_ir, 32'h1000_0000 + 32'(k));
      chk("drain_req", 32'(bus.imem_req), k == 0 ? 32'd0 : 32'd1);
      if (k > 0) chk("drain_addr", bus.imem_addr, 32'(k + 3));
    end
    // redirect while the read of word 9 is in flight
    reset_dut(1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("pre_addr", bus.imem_addr, 32'(k));
      if (k >= 2) chk("pre_ir", bus.fq_ir, 32'h1000_0000 + 32'(k - 2));
    end
    drive(1'b0, 1'b1, 32'd25, 1'b1);
    chk("br_t_req", 32'(bus.imem_req), 32'd0);
    chk("br_t_valid", 32'(bus.fq_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("br_t1_req", 32'(bus.imem_req), 32'd1);
    chk("br_t1_addr", bus.imem_addr, 32'd25);
    chk("br_t1_valid", 32'(bus.fq_valid), 32'd0);
    chk("br_flush", 32'(bus.flush_cnt), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("br_t2_valid", 32'(bus.fq_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("br_t3_valid", 32'(bus.fq_valid), 32'd1);
    chk("br_t3_ir", bus.fq_ir, mem(32'd25));
    chk("br_t3_npc", bus.fq_npc, 32'd26);
    // credit-full queue (count 3 + inflight) with push and pop in the same cycle
    reset_dut(1'b0);
    repeat (4) drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("pp_count", 32'(dut.r_count), 32'd3);
    chk("pp_inflight", 32'(dut.r_inflight), 32'd1);
    chk("pp_ir", bus.fq_ir, mem(32'd0));
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("pp_count_after", 32'(dut.r_count), 32'd3);
    chk("pp_req", 32'(bus.imem_req), 32'd1);
    chk("pp_addr", bus.imem_addr, 32'd4);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("pp_no_req", 32'(bus.imem_req), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("pp_full", 32'(dut.r_count), 32'd4);
    chk("pp_order0", bus.fq_ir, mem(32'd1));
    for (int k = 2; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("pp_order", bus.fq_ir, mem(32'(k)));
    end
    // reset mid-stream with count 3 and a read in flight
    reset_dut(1'b0);
    repeat (4) drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    chk("mr_count", 32'(dut.r_count), 32'd3);
    chk("mr_inflight", 32'(dut.r_inflight), 32'd1);
    chk("mr_req", 32'(bus.imem_req), 32'd0);
    chk("mr_valid", 32'(bus.fq_valid), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("mr_c0_valid", 32'(bus.fq_valid), 32'd0);
    chk("mr_c0_addr", bus.imem_addr, 32'd0);
    chk("mr_c0_req", 32'(bus.imem_req), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("mr_c1_valid", 32'(bus.fq_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      chk("mr_ir", bus.fq_ir, mem(32'(k)));
      chk("mr_npc", bus.fq_npc, 32'(k + 1));
    end
    // address wrap
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("wr_br_req", 32'(bus.imem_req), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wr_addr0", bus.imem_addr, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wr_addr1", bus.imem_addr, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wr_ir0", bus.fq_ir, 32'h0FFF_FFFF);
    chk("wr_npc0", bus.fq_npc, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wr_ir1", bus.fq_ir, 32'h1000_0000);
    chk("wr_npc1", bus.fq_npc, 32'd1);
    // flush counter saturation
    reset_dut(1'b1);
    repeat (65534) drive(1'b0, 1'b1, 32'd5, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("sat_fffe", 32'(bus.flush_cnt), 32'h0000_FFFE);
    chk("sat_restart", bus.imem_addr, 32'd5);
    drive(1'b0, 1'b1, 32'd7, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("sat_ffff", 32'(bus.flush_cnt), 32'h0000_FFFF);
    repeat (3) drive(1'b0, 1'b1, 32'd9, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("sat_hold", 32'(bus.flush_cnt), 32'h0000_FFFF);
    chk("sat_latest", bus.imem_addr, 32'd9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
